// File: rtl/vga_sram_pixel_reader_pkg.sv
// Shared VGA/SRAM definitions for the frame-buffer reader.
//
// Holds the default raster geometry, the AXI OKAY response code, the raster
// counter width, the reader FSM state encoding and a helper that turns a
// (row, column) position into a linear pixel index.
package vga_sram_pixel_reader_pkg;

    localparam int H_VISIBLE_DEFAULT = 640;
    localparam int V_VISIBLE_DEFAULT = 480;
    localparam int COUNTER_WIDTH     = 10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_HOLD
    } reader_state_t;

    // Linear frame-buffer index of a raster position; the caller truncates
    // the result to its address width.
    function automatic int unsigned pixel_index(
        input logic [COUNTER_WIDTH-1:0] row,
        input logic [COUNTER_WIDTH-1:0] column,
        input int unsigned              h_visible
    );
        return 32'(row) * h_visible + 32'(column);
    endfunction

endpackage

// File: rtl/vga_sram_pixel_reader_if.sv
// AXI-Lite read channels (AR and R) between the pixel reader and the SRAM
// controller.
//
// Signals:
//   m_axi_araddr / m_axi_arvalid / m_axi_arready : read address channel
//   m_axi_rdata / m_axi_rresp / m_axi_rvalid / m_axi_rready : read data channel
// Modports:
//   master : the pixel reader side
//   slave  : the SRAM controller side
interface vga_sram_pixel_reader_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
);

    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

endinterface

// File: rtl/vga_sram_pixel_reader_raster_counter.sv
// Column/row raster position of the next pixel to fetch, plus decode of
// whether that position is the first pixel of the frame, the last pixel of
// a line or the last pixel of the frame.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   advance    : step to the next raster position (row-major, wraps at frame end)
//   column,row : current position
//   at_sof     : position is (0,0)
//   at_eol     : position is the last column
//   at_eof     : position is the last column of the last row
module vga_sram_pixel_reader_raster_counter
    import vga_sram_pixel_reader_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEFAULT,
    parameter int V_VISIBLE = V_VISIBLE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     advance,
    output logic [COUNTER_WIDTH-1:0] column,
    output logic [COUNTER_WIDTH-1:0] row,
    output logic                     at_sof,
    output logic                     at_eol,
    output logic                     at_eof
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_COL = COUNTER_WIDTH'(H_VISIBLE - 1);
    localparam logic [COUNTER_WIDTH-1:0] LAST_ROW = COUNTER_WIDTH'(V_VISIBLE - 1);

    assign at_sof = (column == '0) && (row == '0);
    assign at_eol = (column == LAST_COL);
    assign at_eof = at_eol && (row == LAST_ROW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            column <= '0;
            row    <= '0;
        end else if (advance) begin
            if (at_eol) begin
                column <= '0;
                row    <= (row == LAST_ROW) ? '0 : row + COUNTER_WIDTH'(1);
            end else begin
                column <= column + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/vga_sram_pixel_reader.sv
// Frame-buffer read master: walks the visible raster row-major, issues one
// AXI-Lite read per pixel (one outstanding at a time) and presents each
// returned word on a valid/ready pixel stream with sof/eol/eof markers.
//
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   enable       : level; start or continue fetching
//   axi          : AXI-Lite read master (AR and R channels)
//   pixel_data   : pixel word
//   pixel_valid  : pixel available
//   pixel_ready  : consumer accepts pixel
//   pixel_sof    : pixel is (row 0, col 0)
//   pixel_eol    : pixel is the last column of a line
//   pixel_eof    : pixel is the last pixel of the frame
//   read_error   : sticky, set by any non-OKAY read response
module vga_sram_pixel_reader
    import vga_sram_pixel_reader_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int H_VISIBLE      = H_VISIBLE_DEFAULT,
    parameter int V_VISIBLE      = V_VISIBLE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    vga_sram_pixel_reader_if.master   axi,
    output logic [AXI_DATA_WIDTH-1:0] pixel_data,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic                      pixel_sof,
    output logic                      pixel_eol,
    output logic                      pixel_eof,
    output logic                      read_error
);

    reader_state_t state;
    reader_state_t state_next;

    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic                      arvalid_q;
    logic                      rready_q;

    logic [COUNTER_WIDTH-1:0]  column;
    logic [COUNTER_WIDTH-1:0]  row;
    logic                      at_sof;
    logic                      at_eol;
    logic                      at_eof;

    logic                      load_addr;
    logic                      ar_done;
    logic                      r_done;
    logic                      px_done;
    logic [AXI_ADDR_WIDTH-1:0] addr_next;

    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_arvalid = arvalid_q;
    assign axi.m_axi_rready  = rready_q;

    // Counters already point at the next pixel, so this is the next request.
    assign addr_next = AXI_ADDR_WIDTH'(pixel_index(row, column, H_VISIBLE));

    // The counters advance on the data handshake, so their decode still
    // describes the pixel being captured at that moment.
    vga_sram_pixel_reader_raster_counter #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .advance (r_done),
        .column  (column),
        .row     (row),
        .at_sof  (at_sof),
        .at_eol  (at_eol),
        .at_eof  (at_eof)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // arvalid is high for the whole of ADDR and rready for the whole of DATA,
    // so the handshakes reduce to the slave-side signal alone.
    always_comb begin
        state_next = state;
        load_addr  = 1'b0;
        ar_done    = 1'b0;
        r_done     = 1'b0;
        px_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    load_addr  = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi.m_axi_arready) begin
                    ar_done    = 1'b1;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (axi.m_axi_rvalid) begin
                    r_done     = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pixel_ready) begin
                    px_done = 1'b1;
                    if (enable) begin
                        load_addr  = 1'b1;
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_sof   <= 1'b0;
            pixel_eol   <= 1'b0;
            pixel_eof   <= 1'b0;
            read_error  <= 1'b0;
        end else begin
            if (load_addr) begin
                araddr_q  <= addr_next;
                arvalid_q <= 1'b1;
            end
            if (ar_done) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (r_done) begin
                rready_q    <= 1'b0;
                pixel_data  <= axi.m_axi_rdata;
                pixel_valid <= 1'b1;
                pixel_sof   <= at_sof;
                pixel_eol   <= at_eol;
                pixel_eof   <= at_eof;
                if (axi.m_axi_rresp != RESP_OKAY) begin
                    read_error <= 1'b1;
                end
            end
            if (px_done) begin
                pixel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sram_pixel_reader.sv
// Bench for vga_sram_pixel_reader. Runs a 640x4 raster so that line wrap at
// column 639 and a full frame wrap both fit in a short run. The bench plays
// the SRAM slave and the pixel consumer; each returned word is pushed to a
// scoreboard with its expected markers and popped when the pixel is taken.
module tb_vga_sram_pixel_reader;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int H      = 640;
    localparam int V      = 4;
    localparam int FRAME  = H * V;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } pix_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [DATA_W-1:0] pixel_data;
    logic              pixel_valid;
    logic              pixel_ready;
    logic              pixel_sof;
    logic              pixel_eol;
    logic              pixel_eof;
    logic              read_error;

    int   assertions = 0;
    int   failures   = 0;
    int   exp_index  = 0;
    logic exp_err    = 1'b0;
    pix_t sb_q[$];

    vga_sram_pixel_reader_if #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W)) bus ();

    vga_sram_pixel_reader #(
        .AXI_ADDR_WIDTH (ADDR_W),
        .AXI_DATA_WIDTH (DATA_W),
        .H_VISIBLE      (H),
        .V_VISIBLE      (V)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .axi         (bus),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_sof   (pixel_sof),
        .pixel_eol   (pixel_eol),
        .pixel_eof   (pixel_eof),
        .read_error  (read_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (pixel index %0d)", tag, actual, expected, exp_index);
        end
    endtask

    // One complete pixel: AR handshake after ar_wait stall cycles, R beat on
    // the next cycle, then the consumer holds pixel_ready low for hold cycles.
    task automatic applyStimulus(input int ar_wait, input logic [DATA_W-1:0] data,
                                 input logic [1:0] resp, input int hold, input bit drop_enable);
        int   n;
        pix_t exp;
        n = 0;
        while (bus.m_axi_arvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("arvalid", 32'(bus.m_axi_arvalid), 32'd1);
        checkOutput("araddr", 32'(bus.m_axi_araddr), 32'(exp_index));
        if (drop_enable) enable = 1'b0;
        for (int k = 0; k < ar_wait; k++) begin
            @(negedge clk);
            checkOutput("ar_stall_valid", 32'(bus.m_axi_arvalid), 32'd1);
            checkOutput("ar_stall_addr", 32'(bus.m_axi_araddr), 32'(exp_index));
        end
        bus.m_axi_arready = 1'b1;
        @(negedge clk);
        bus.m_axi_arready = 1'b0;
        checkOutput("arvalid_drop", 32'(bus.m_axi_arvalid), 32'd0);
        checkOutput("rready_rise", 32'(bus.m_axi_rready), 32'd1);

        exp.data = data;
        exp.sof  = (exp_index == 0);
        exp.eol  = ((exp_index % H) == H - 1);
        exp.eof  = (exp_index == FRAME - 1);
        sb_q.push_back(exp);
        if (resp != 2'b00) exp_err = 1'b1;

        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = data;
        bus.m_axi_rresp  = resp;
        @(negedge clk);
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rresp  = 2'b00;
        checkOutput("rready_drop", 32'(bus.m_axi_rready), 32'd0);
        checkOutput("read_error", 32'(read_error), 32'(exp_err));

        for (int k = 0; k < hold; k++) begin
            checkOutput("hold_valid", 32'(pixel_valid), 32'd1);
            checkOutput("hold_arvalid", 32'(bus.m_axi_arvalid), 32'd0);
            if (sb_q.size() > 0) checkOutput("hold_data", 32'(pixel_data), 32'(sb_q[0].data));
            @(negedge clk);
        end

        checkOutput("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            checkOutput("pixel_valid", 32'(pixel_valid), 32'd1);
            checkOutput("pixel_data", 32'(pixel_data), 32'(exp.data));
            checkOutput("pixel_sof", 32'(pixel_sof), 32'(exp.sof));
            checkOutput("pixel_eol", 32'(pixel_eol), 32'(exp.eol));
            checkOutput("pixel_eof", 32'(pixel_eof), 32'(exp.eof));
        end
        pixel_ready = 1'b1;
        @(negedge clk);
        pixel_ready = 1'b0;
        checkOutput("valid_drop", 32'(pixel_valid), 32'd0);
        checkOutput("arvalid_after_take", 32'(bus.m_axi_arvalid), 32'(enable));
        exp_index = (exp_index + 1) % FRAME;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset             = 1'b0;
        enable            = 1'b1;
        pixel_ready       = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        #2 reset = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_araddr", 32'(bus.m_axi_araddr), 32'd0);
            checkOutput("rst_arvalid", 32'(bus.m_axi_arvalid), 32'd0);
            checkOutput("rst_rready", 32'(bus.m_axi_rready), 32'd0);
            checkOutput("rst_pixel_data", 32'(pixel_data), 32'd0);
            checkOutput("rst_pixel_valid", 32'(pixel_valid), 32'd0);
            checkOutput("rst_sof", 32'(pixel_sof), 32'd0);
            checkOutput("rst_eol", 32'(pixel_eol), 32'd0);
            checkOutput("rst_eof", 32'(pixel_eof), 32'd0);
            checkOutput("rst_read_error", 32'(read_error), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_arvalid", 32'(bus.m_axi_arvalid), 32'd1);
        checkOutput("post_rst_araddr", 32'(bus.m_axi_araddr), 32'd0);

        applyStimulus(0, 16'hA5A0, 2'b00, 0, 1'b0);
        applyStimulus(0, 16'h1234, 2'b00, 5, 1'b0);
        for (int k = 2; k < 5; k++) begin
            applyStimulus(1, 16'($urandom), 2'b00, 0, 1'b0);
        end
        applyStimulus(0, 16'hBEEF, 2'b10, 0, 1'b0);
        applyStimulus(4, 16'h0F0F, 2'b00, 1, 1'b1);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("idle_arvalid", 32'(bus.m_axi_arvalid), 32'd0);
            checkOutput("idle_valid", 32'(pixel_valid), 32'd0);
        end
        enable = 1'b1;

        while (exp_index != 2) begin
            applyStimulus(0, 16'($urandom), 2'b00, 0, 1'b0);
        end
        checkOutput("final_read_error", 32'(read_error), 32'd1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
